// File: rtl/arb_rr_bin.sv
// Round-robin arbiter with a registered binary grant held until the valid/ready transfer.
// Define ARB_RR_BIN_ROUND_ROBIN_EN for round-robin; leave it undefined for fixed lowest-index priority.
module arb_rr_bin #(
    parameter  int WIDTH          = 16,
    parameter  int SPLIT          = 4,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req,
    output logic                 vld,
    input  logic                 rdy,
    output logic [WIDTH_LOG-1:0] bin,
    output logic [WIDTH-1:0]     oht
);

    localparam int NGRP = (WIDTH + SPLIT - 1) / SPLIT;
    localparam int PADW = NGRP * SPLIT;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t               state_q, state_d;
    logic [WIDTH_LOG-1:0] bin_q, bin_d;
    logic [WIDTH_LOG-1:0] start;
    logic [WIDTH-1:0]     srch, hmask, hi;
    logic [WIDTH_LOG-1:0] win;
    logic                 any;
`ifdef ARB_RR_BIN_ROUND_ROBIN_EN
    logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
    logic [WIDTH_LOG-1:0] bin_inc;
`endif

    // Lowest set index; IMPLEMENTATION 0 resolves SPLIT-wide groups first, like mux_bin's tree.
    function automatic logic [WIDTH_LOG-1:0] first_set(input logic [WIDTH-1:0] v);
        logic [PADW-1:0]      vp;
        logic [NGRP-1:0]      grp_any;
        logic [WIDTH_LOG-1:0] grp_idx [NGRP];
        logic [WIDTH_LOG-1:0] idx;
        vp  = PADW'(v);
        idx = '0;
        if (IMPLEMENTATION == 0) begin
            for (int g = 0; g < NGRP; g++) begin
                grp_any[g] = |vp[g*SPLIT +: SPLIT];
                grp_idx[g] = '0;
                for (int j = SPLIT - 1; j >= 0; j--) begin
                    if (vp[g*SPLIT + j]) grp_idx[g] = WIDTH_LOG'(g*SPLIT + j);
                end
            end
            for (int g = NGRP - 1; g >= 0; g--) begin
                if (grp_any[g]) idx = grp_idx[g];
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (v[i]) idx = WIDTH_LOG'(i);
            end
        end
        return idx;
    endfunction

    assign vld = (state_q == GRANT);
    assign bin = bin_q;
    assign oht = vld ? (WIDTH'(1) << bin_q) : '0;

`ifdef ARB_RR_BIN_ROUND_ROBIN_EN
    assign bin_inc = (bin_q == WIDTH_LOG'(WIDTH - 1)) ? '0 : bin_q + 1'b1;
    assign start   = vld ? bin_inc : ptr_q;
`else
    assign start   = '0;
`endif

    // Rotated search: bits at or above start first, then wrap to the full vector.
    always_comb begin
        srch  = vld ? (req & ~oht) : req;
        hmask = ~((WIDTH'(1) << start) - WIDTH'(1));
        hi    = srch & hmask;
        any   = |srch;
        win   = (|hi) ? first_set(hi) : first_set(srch);
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
`ifdef ARB_RR_BIN_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = GRANT;
                    bin_d   = win;
                end
            end
            GRANT: begin
                if (rdy) begin
`ifdef ARB_RR_BIN_ROUND_ROBIN_EN
                    ptr_d = bin_inc;
`endif
                    if (any) bin_d   = win;
                    else     state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
`ifdef ARB_RR_BIN_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
`ifdef ARB_RR_BIN_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_arb_rr_bin.sv
// Randomized and directed bench for arb_rr_bin against a scan-order reference model.
module tb_arb_rr_bin;

    localparam int W = 16;

`ifdef ARB_RR_BIN_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  req;
    logic          vld;
    logic          rdy;
    logic [3:0]    bin;
    logic [W-1:0]  oht;

    int n_chk = 0;
    int n_err = 0;

    bit m_vld = 1'b0;
    int m_bin = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    arb_rr_bin #(.WIDTH(W), .SPLIT(4), .IMPLEMENTATION(0)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .vld(vld),
        .rdy(rdy),
        .bin(bin),
        .oht(oht)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // First requester in the order start, start+1, ..., wrapping; -1 if none.
    function automatic int search(input logic [W-1:0] r, input int from);
        for (int k = 0; k < W; k++) begin
            int idx;
            idx = (from + k) % W;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [W-1:0] r, input bit y, input bit rs);
        int w;
        int np;
        if (rs) begin
            m_vld = 1'b0;
            m_bin = 0;
            m_ptr = 0;
        end else if (!m_vld) begin
            w = search(r, RR ? m_ptr : 0);
            if (w >= 0) begin
                m_vld = 1'b1;
                m_bin = w;
            end
        end else if (y) begin
            np = (m_bin + 1) % W;
            m_ptr = np;
            w = search(r & ~(W'(1) << m_bin), RR ? np : 0);
            if (w >= 0) m_bin = w;
            else        m_vld = 1'b0;
        end
    endtask

    // Called at a falling edge: drive, advance model, sample 1 time unit after the rising edge.
    task automatic cycle(input logic [W-1:0] r, input bit y, input bit rs, input string tag);
        req = r;
        rdy = y;
        rst = rs;
        model_step(r, y, rs);
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, 32'(vld), 32'(m_vld));
        chk({tag, "_oht"}, 32'(oht), m_vld ? (32'(1) << m_bin) : 32'(0));
        if (m_vld || rs) chk({tag, "_bin"}, 32'(bin), 32'(m_bin));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        rdy = 1'b0;
        @(negedge clk);

        cycle(16'hFFFF, 1'b0, 1'b1, "reset");
        cycle(16'hFFFF, 1'b0, 1'b1, "reset");
        chk("reset_bin0", 32'(bin), 32'(0));
        cycle(16'hFFFF, 1'b0, 1'b0, "first");
        chk("first_grant", 32'(bin), 32'(0));

        cycle(16'hFFFF, 1'b0, 1'b1, "rst_rot");
        for (int i = 0; i < 18; i++) cycle(16'hFFFF, 1'b1, 1'b0, "rotate");

        cycle(16'h0000, 1'b0, 1'b1, "rst_bp");
        cycle(16'h0120, 1'b0, 1'b0, "bp");
        cycle(16'h0120, 1'b0, 1'b0, "bp");
        for (int i = 0; i < 3; i++) cycle(16'h0100, 1'b0, 1'b0, "bp_chg");
        chk("bp_hold", 32'(bin), 32'(5));
        cycle(16'h0100, 1'b1, 1'b0, "bp_rel");
        chk("bp_next", 32'(bin), 32'(8));
        cycle(16'h0000, 1'b1, 1'b0, "bp_done");

        cycle(16'h0000, 1'b0, 1'b1, "rst_wrap");
        cycle(16'h2000, 1'b1, 1'b0, "wrap13");
        cycle(16'h2000, 1'b1, 1'b0, "wrap13");
        cycle(16'h0003, 1'b1, 1'b0, "wrap");
        chk("wrap_first", 32'(bin), 32'(0));
        cycle(16'h0003, 1'b1, 1'b0, "wrap");
        chk("wrap_second", 32'(bin), 32'(1));

        cycle(16'h0000, 1'b0, 1'b1, "rst_sole");
        for (int i = 0; i < 6; i++) begin
            cycle(16'h0200, 1'b1, 1'b0, "sole");
            chk("sole_pattern", 32'(vld), 32'((i % 2) == 0));
        end

        cycle(16'h0000, 1'b0, 1'b1, "rst_fp");
        for (int i = 0; i < 8; i++) begin
            cycle(16'h8011, 1'b1, 1'b0, "prio");
            if (!RR) chk("fp_not15", 32'(bin != 4'd15), 32'(1));
        end

        cycle(16'h0000, 1'b1, 1'b1, "rst_rand");
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] r;
            bit y;
            bit rs;
            r  = W'($urandom());
            if ($urandom_range(0, 1) == 0) r = r & W'($urandom()) & W'($urandom());
            y  = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 149) == 0);
            cycle(r, y, rs, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
